// File: rtl/lsq_moment_acc.sv
// Streaming power-sum accumulator for least-squares polynomial fitting.
// Produces sum(x^k) for k = 0..2*DEG and sum(x^k * y) for k = 0..DEG over a programmable run.
module lsq_moment_acc #(
   parameter int DEG   = 2,
   parameter int XW    = 12,
   parameter int YW    = 16,
   parameter int ACC_W = 64,
   parameter int CNT_W = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [CNT_W-1:0]            n_samples,
   input  logic                        abort,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [XW-1:0]               xi,
   input  logic [YW-1:0]               yi,
   output logic                        out_valid,
   output logic                        busy,
   output logic [CNT_W-1:0]            count,
   output logic [(2*DEG+1)*ACC_W-1:0]  sx,
   output logic [(DEG+1)*ACC_W-1:0]    sxy,
   output logic                        ovf
);

   localparam int NX   = 2*DEG + 1;
   localparam int NY   = DEG + 1;
   localparam int MAXW = 2*DEG*XW + YW;
   // One guard bit above the widest of term and accumulator, so carries out of ACC_W are visible.
   localparam int SW   = ((MAXW > ACC_W) ? MAXW : ACC_W) + 1;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] n_lat;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_inc;
   logic [ACC_W-1:0] sx_q  [NX];
   logic [ACC_W-1:0] sxy_q [NY];
   logic             ovf_q;
   logic             start_ok;
   logic             accept;
   logic             last;

   logic [SW-1:0]    x_ext;
   logic [SW-1:0]    y_ext;
   logic [SW-1:0]    pw      [NX];
   logic [SW-1:0]    xyt     [NY];
   logic [SW-1:0]    sx_sum  [NX];
   logic [SW-1:0]    sxy_sum [NY];
   logic [NX-1:0]    sx_ovf;
   logic [NY-1:0]    sxy_ovf;

   assign start_ok  = (state == IDLE) && start;
   assign accept    = (state == ACC) && in_valid && !abort;
   assign count_inc = count_q + CNT_W'(1);
   assign last      = (count_inc == n_lat);

   // Exact powers and products, then wide sums whose bits above ACC_W flag overflow.
   always_comb begin
      x_ext = SW'(xi);
      y_ext = SW'(yi);
      pw[0] = SW'(1);
      for (int k = 1; k < NX; k++) begin
         pw[k] = pw[k-1] * x_ext;
      end
      for (int k = 0; k < NX; k++) begin
         sx_sum[k] = SW'(sx_q[k]) + pw[k];
         sx_ovf[k] = |sx_sum[k][SW-1:ACC_W];
      end
      for (int k = 0; k < NY; k++) begin
         xyt[k]     = pw[k] * y_ext;
         sxy_sum[k] = SW'(sxy_q[k]) + xyt[k];
         sxy_ovf[k] = |sxy_sum[k][SW-1:ACC_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (n_samples != '0) ? ACC : DONE;
         ACC: begin
            if (abort) begin
               state_next = IDLE;
            end else if (accept && last) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // An abort landing in DONE suppresses the pulse that would otherwise fire that cycle.
   always_comb begin
      in_ready  = (state == ACC);
      busy      = (state != IDLE);
      out_valid = (state == DONE) && !abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lat   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < NX; k++) sx_q[k] <= '0;
         for (int k = 0; k < NY; k++) sxy_q[k] <= '0;
      end else if (start_ok) begin
         n_lat   <= n_samples;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < NX; k++) sx_q[k] <= '0;
         for (int k = 0; k < NY; k++) sxy_q[k] <= '0;
      end else if (accept) begin
         count_q <= count_inc;
         ovf_q   <= ovf_q | (|sx_ovf) | (|sxy_ovf);
         for (int k = 0; k < NX; k++) sx_q[k] <= sx_sum[k][ACC_W-1:0];
         for (int k = 0; k < NY; k++) sxy_q[k] <= sxy_sum[k][ACC_W-1:0];
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;

   for (genvar g = 0; g < NX; g++) begin : g_sx
      assign sx[g*ACC_W +: ACC_W] = sx_q[g];
   end
   for (genvar g = 0; g < NY; g++) begin : g_sxy
      assign sxy[g*ACC_W +: ACC_W] = sxy_q[g];
   end

endmodule

// File: tb/tb_lsq_moment_acc.sv
// Directed bench for lsq_moment_acc: table-driven runs on a 64-bit instance plus
// hand-written abort, reset and overflow sequences (the latter on a 20-bit instance).
module tb_lsq_moment_acc;

   localparam int DEG = 2;
   localparam int XW  = 12;
   localparam int YW  = 16;
   localparam int CW  = 10;
   localparam int AW  = 64;
   localparam int AW2 = 20;

   logic                    clk;
   logic                    rst_n;

   logic                    start, abort, in_valid, in_ready, out_valid, busy, ovf;
   logic [CW-1:0]           n_samples, count;
   logic [XW-1:0]           xi;
   logic [YW-1:0]           yi;
   logic [(2*DEG+1)*AW-1:0] sx;
   logic [(DEG+1)*AW-1:0]   sxy;

   logic                     start2, abort2, in_valid2, in_ready2, out_valid2, busy2, ovf2;
   logic [CW-1:0]            n_samples2, count2;
   logic [XW-1:0]            xi2;
   logic [YW-1:0]            yi2;
   logic [(2*DEG+1)*AW2-1:0] sx2;
   logic [(DEG+1)*AW2-1:0]   sxy2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int                 n;
      logic [XW-1:0]      xs [4];
      logic [YW-1:0]      ys [4];
      bit                 gappy;
      longint unsigned    esx [5];
      longint unsigned    esxy [3];
   } vec_t;

   vec_t vecs [5];

   lsq_moment_acc #(.DEG(DEG), .XW(XW), .YW(YW), .ACC_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .xi(xi), .yi(yi), .out_valid(out_valid),
      .busy(busy), .count(count), .sx(sx), .sxy(sxy), .ovf(ovf)
   );

   lsq_moment_acc #(.DEG(DEG), .XW(XW), .YW(YW), .ACC_W(AW2), .CNT_W(CW)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .n_samples(n_samples2), .abort(abort2),
      .in_valid(in_valid2), .in_ready(in_ready2), .xi(xi2), .yi(yi2), .out_valid(out_valid2),
      .busy(busy2), .count(count2), .sx(sx2), .sxy(sxy2), .ovf(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint unsigned actual,
                              input longint unsigned expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkSums(input string tag, input int idx);
      for (int k = 0; k < 5; k++)
         checkOutput($sformatf("%s sx[%0d]", tag, k), sx[k*AW +: AW], vecs[idx].esx[k]);
      for (int k = 0; k < 3; k++)
         checkOutput($sformatf("%s sxy[%0d]", tag, k), sxy[k*AW +: AW], vecs[idx].esxy[k]);
   endtask

   // Runs one table record; inputs change on negedge, outputs are observed on negedge.
   task automatic applyStimulus(input int idx);
      int  sent;
      int  pulses;
      int  pulse_at;
      int  last_at;
      bit  acc;
      vec_t v;
      v        = vecs[idx];
      sent     = 0;
      pulses   = 0;
      pulse_at = -1;
      last_at  = (v.n == 0) ? 0 : -1;
      @(negedge clk);
      start     = 1'b1;
      n_samples = CW'(v.n);
      @(negedge clk);
      start     = 1'b0;
      n_samples = CW'(3);
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (out_valid) begin
            pulses++;
            pulse_at = cyc;
         end
         if (last_at >= 0 && cyc > last_at) break;
         if (sent < v.n) begin
            in_valid = v.gappy ? ((cyc % 3) == 0) : 1'b1;
            xi       = v.xs[sent];
            yi       = v.ys[sent];
            start    = v.gappy && (sent == 2);
         end else begin
            in_valid = 1'b0;
            start    = 1'b0;
         end
         acc = in_valid && in_ready;
         @(negedge clk);
         if (acc) begin
            sent++;
            if (sent == v.n) last_at = cyc + 1;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      checkOutput($sformatf("vec%0d completed", idx), longint'(last_at >= 0), 1);
      checkOutput($sformatf("vec%0d out_valid pulses", idx), longint'(pulses), 1);
      checkOutput($sformatf("vec%0d out_valid cycle", idx), longint'(pulse_at), longint'(last_at));
      checkOutput($sformatf("vec%0d busy after", idx), longint'(busy), 0);
      checkOutput($sformatf("vec%0d count", idx), longint'(count), longint'(v.n));
      checkOutput($sformatf("vec%0d ovf", idx), longint'(ovf), 0);
      checkSums($sformatf("vec%0d", idx), idx);
   endtask

   initial begin
      vecs[0] = '{n: 4, xs: '{1, 2, 3, 4}, ys: '{10, 20, 30, 40}, gappy: 1'b0,
                  esx: '{4, 10, 30, 100, 354}, esxy: '{100, 300, 1000}};
      vecs[1] = '{n: 4, xs: '{1, 2, 3, 4}, ys: '{10, 20, 30, 40}, gappy: 1'b1,
                  esx: '{4, 10, 30, 100, 354}, esxy: '{100, 300, 1000}};
      vecs[2] = '{n: 0, xs: '{0, 0, 0, 0}, ys: '{0, 0, 0, 0}, gappy: 1'b0,
                  esx: '{0, 0, 0, 0, 0}, esxy: '{0, 0, 0}};
      vecs[3] = '{n: 1, xs: '{2, 0, 0, 0}, ys: '{3, 0, 0, 0}, gappy: 1'b0,
                  esx: '{1, 2, 4, 8, 16}, esxy: '{3, 6, 12}};
      vecs[4] = '{n: 3, xs: '{0, 4095, 5, 0}, ys: '{65535, 1, 2, 0}, gappy: 1'b0,
                  esx: '{3, 4100, 16769050, 64'd68669157500, 64'd281200199451250},
                  esxy: '{65538, 4105, 16769075}};

      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; n_samples = '0; xi = '0; yi = '0;
      start2 = 1'b0; abort2 = 1'b0; in_valid2 = 1'b0; n_samples2 = '0; xi2 = '0; yi2 = '0;

      #12;
      checkOutput("reset in_ready", longint'(in_ready), 0);
      checkOutput("reset out_valid", longint'(out_valid), 0);
      checkOutput("reset busy", longint'(busy), 0);
      checkOutput("reset count", longint'(count), 0);
      checkOutput("reset ovf", longint'(ovf), 0);
      checkOutput("reset sx nonzero", longint'(|sx), 0);
      checkOutput("reset sxy nonzero", longint'(|sxy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idle busy", longint'(busy), 0);
      checkOutput("idle out_valid", longint'(out_valid), 0);
      checkOutput("idle sx nonzero", longint'(|sx), 0);

      for (int i = 0; i < 5; i++) applyStimulus(i);

      // Abort after two accepted samples; later samples must be ignored.
      @(negedge clk);
      start = 1'b1; n_samples = CW'(4);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; xi = XW'(i + 1); yi = YW'(10 * (i + 1));
         @(negedge clk);
      end
      abort = 1'b1; xi = XW'(3); yi = YW'(30);
      checkOutput("abort cycle out_valid", longint'(out_valid), 0);
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort busy next", longint'(busy), 0);
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 3; i++) begin
            if (out_valid) pulses++;
            @(negedge clk);
         end
         checkOutput("abort no out_valid", longint'(pulses), 0);
      end
      in_valid = 1'b0;
      checkOutput("abort count", longint'(count), 2);
      checkOutput("abort partial sx[1]", sx[1*AW +: AW], 3);
      checkOutput("abort partial sx[4]", sx[4*AW +: AW], 17);
      checkOutput("abort partial sxy[2]", sxy[2*AW +: AW], 90);
      applyStimulus(0);

      // Reset asserted mid-run returns everything to zero at once.
      @(negedge clk);
      start = 1'b1; n_samples = CW'(4);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; xi = XW'(7); yi = YW'(9);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrun reset busy", longint'(busy), 0);
      checkOutput("midrun reset count", longint'(count), 0);
      checkOutput("midrun reset sx nonzero", longint'(|sx), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Overflow on the narrow instance: two samples of x=4095.
      @(negedge clk);
      start2 = 1'b1; n_samples2 = CW'(2);
      @(negedge clk);
      start2 = 1'b0; in_valid2 = 1'b1; xi2 = XW'(4095); yi2 = '0;
      repeat (2) @(negedge clk);
      in_valid2 = 1'b0;
      checkOutput("ovf run out_valid", longint'(out_valid2), 1);
      checkOutput("ovf flag", longint'(ovf2), 1);
      checkOutput("ovf sx[0]", longint'(sx2[0 +: AW2]), 2);
      checkOutput("ovf sx[1]", longint'(sx2[AW2 +: AW2]), 8190);
      checkOutput("ovf sx[2]", longint'(sx2[2*AW2 +: AW2]), 1032194);
      @(negedge clk);
      start2 = 1'b1; n_samples2 = CW'(1);
      @(negedge clk);
      start2 = 1'b0;
      checkOutput("ovf cleared by start", longint'(ovf2), 0);
      in_valid2 = 1'b1; xi2 = XW'(1); yi2 = YW'(1);
      @(negedge clk);
      in_valid2 = 1'b0;
      checkOutput("post-ovf out_valid", longint'(out_valid2), 1);
      checkOutput("post-ovf sx[4]", longint'(sx2[4*AW2 +: AW2]), 1);
      checkOutput("post-ovf ovf", longint'(ovf2), 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
